// File: rtl/vga_sincronizador_if.sv
// Scan-timing bundle from the VGA sync generator to the drawing stages.
interface vga_sincronizador_if;
   logic       pixelEn;
   logic [9:0] coluna;
   logic [9:0] linha;
   logic       areaAtiva;
   logic       hsync;
   logic       vsync;
   logic       fimQuadro;
   logic [7:0] quadro;

   modport master (
      output pixelEn, coluna, linha, areaAtiva, hsync, vsync, fimQuadro, quadro
   );

   modport slave (
      input  pixelEn, coluna, linha, areaAtiva, hsync, vsync, fimQuadro, quadro
   );
endinterface

// File: rtl/vga_sincronizador.sv
// VGA timing generator: pixel-rate enable, scan coordinates, sync pulses and
// frame strobes. Every flag is registered from the next counter value so it
// always decodes the coordinates driven in the same clk.
module vga_sincronizador #(
   parameter int unsigned DIV_PIXEL = 2,
   parameter int unsigned H_VIS     = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VIS     = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned SYNC_POL  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   vga_sincronizador_if.master   vga
);

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned DIV_W   = 2;
   localparam int unsigned Q_W     = 8;
   localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [DIV_W-1:0] DIV_ULT  = DIV_W'(DIV_PIXEL - 1);
   localparam logic [CNT_W-1:0] COL_ULT  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] LIN_ULT  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HS_INI   = CNT_W'(H_VIS + H_FP);
   localparam logic [CNT_W-1:0] HS_FIM   = CNT_W'(H_VIS + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_INI   = CNT_W'(V_VIS + V_FP);
   localparam logic [CNT_W-1:0] VS_FIM   = CNT_W'(V_VIS + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] COL_VIS  = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] LIN_VIS  = CNT_W'(V_VIS);
   localparam logic             SYNC_ATV = 1'(SYNC_POL);

   logic [DIV_W-1:0] div;
   logic             pixelEn;
   logic [CNT_W-1:0] coluna;
   logic [CNT_W-1:0] linha;
   logic [Q_W-1:0]   quadro;
   logic             areaAtiva;
   logic             hsync;
   logic             vsync;
   logic             fimQuadro;

   logic [DIV_W-1:0] divNext;
   logic             pixelEnNext;
   logic             fimLinha;
   logic             ultLinha;
   logic [CNT_W-1:0] colunaNext;
   logic [CNT_W-1:0] linhaNext;
   logic [Q_W-1:0]   quadroNext;
   logic             areaNext;
   logic             hsyncNext;
   logic             vsyncNext;
   logic             fimNext;

   // Next-state of divider, scan counters and the flags decoding them
   always_comb begin
      divNext     = (div == DIV_ULT) ? '0 : div + DIV_W'(1);
      pixelEnNext = (div == DIV_ULT);
      fimLinha    = pixelEn && (coluna == COL_ULT);
      ultLinha    = (linha == LIN_ULT);
      colunaNext  = coluna;
      linhaNext   = linha;
      quadroNext  = quadro;
      if (pixelEn) begin
         colunaNext = fimLinha ? '0 : coluna + CNT_W'(1);
      end
      if (fimLinha) begin
         linhaNext = ultLinha ? '0 : linha + CNT_W'(1);
         if (ultLinha) begin
            quadroNext = quadro + Q_W'(1);
         end
      end
      areaNext  = (colunaNext < COL_VIS) && (linhaNext < LIN_VIS);
      hsyncNext = ((colunaNext >= HS_INI) && (colunaNext < HS_FIM)) ? SYNC_ATV : ~SYNC_ATV;
      vsyncNext = ((linhaNext >= VS_INI) && (linhaNext < VS_FIM)) ? SYNC_ATV : ~SYNC_ATV;
      fimNext   = pixelEnNext && (colunaNext == COL_ULT) && (linhaNext == LIN_ULT);
   end

   // Timing registers; reset parks the scan at (0,0) with syncs inactive
   always_ff @(posedge clk) begin
      if (reset) begin
         div       <= '0;
         pixelEn   <= 1'b0;
         coluna    <= '0;
         linha     <= '0;
         quadro    <= '0;
         areaAtiva <= 1'b1;
         hsync     <= ~SYNC_ATV;
         vsync     <= ~SYNC_ATV;
         fimQuadro <= 1'b0;
      end else begin
         div       <= divNext;
         pixelEn   <= pixelEnNext;
         coluna    <= colunaNext;
         linha     <= linhaNext;
         quadro    <= quadroNext;
         areaAtiva <= areaNext;
         hsync     <= hsyncNext;
         vsync     <= vsyncNext;
         fimQuadro <= fimNext;
      end
   end

   assign vga.pixelEn   = pixelEn;
   assign vga.coluna    = coluna;
   assign vga.linha     = linha;
   assign vga.quadro    = quadro;
   assign vga.areaAtiva = areaAtiva;
   assign vga.hsync     = hsync;
   assign vga.vsync     = vsync;
   assign vga.fimQuadro = fimQuadro;

endmodule

// File: tb/tb_vga_sincronizador.sv
// Bench for vga_sincronizador: default 640x480 timing instance (A) plus a
// DIV_PIXEL=1 instance with tiny totals (B, 14x7) for frame-level behaviour.
module tb_vga_sincronizador;

   logic clk = 1'b0;
   logic rstA;
   logic rstB;

   vga_sincronizador_if ifA ();
   vga_sincronizador_if ifB ();

   vga_sincronizador dutA (
      .clk   (clk),
      .reset (rstA),
      .vga   (ifA)
   );

   vga_sincronizador #(
      .DIV_PIXEL (1),
      .H_VIS (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_VIS (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .SYNC_POL (0)
   ) dutB (
      .clk   (clk),
      .reset (rstB),
      .vga   (ifB)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned n;
      bit          sel;
      int          col;
      int          lin;
      int          pe;
      int          hs;
      int          vs;
      int          area;
      int          fim;
      int          q;
   } vec_t;

   vec_t        tbl[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   function automatic vec_t mk(int unsigned n, bit sel, int col, int lin, int pe,
                               int hs, int vs, int area, int fim, int q);
      vec_t v;
      v.n = n; v.sel = sel; v.col = col; v.lin = lin; v.pe = pe;
      v.hs = hs; v.vs = vs; v.area = area; v.fim = fim; v.q = q;
      return v;
   endfunction

   task automatic cmpVec(input vec_t v);
      string t;
      t = $sformatf("%s@%0d", v.sel ? "B" : "A", v.n);
      if (v.sel) begin
         chk({t, " coluna"},    int'(ifB.coluna),    v.col);
         chk({t, " linha"},     int'(ifB.linha),     v.lin);
         chk({t, " pixelEn"},   int'(ifB.pixelEn),   v.pe);
         chk({t, " hsync"},     int'(ifB.hsync),     v.hs);
         chk({t, " vsync"},     int'(ifB.vsync),     v.vs);
         chk({t, " areaAtiva"}, int'(ifB.areaAtiva), v.area);
         chk({t, " fimQuadro"}, int'(ifB.fimQuadro), v.fim);
         chk({t, " quadro"},    int'(ifB.quadro),    v.q);
      end else begin
         chk({t, " coluna"},    int'(ifA.coluna),    v.col);
         chk({t, " linha"},     int'(ifA.linha),     v.lin);
         chk({t, " pixelEn"},   int'(ifA.pixelEn),   v.pe);
         chk({t, " hsync"},     int'(ifA.hsync),     v.hs);
         chk({t, " vsync"},     int'(ifA.vsync),     v.vs);
         chk({t, " areaAtiva"}, int'(ifA.areaAtiva), v.area);
         chk({t, " fimQuadro"}, int'(ifA.fimQuadro), v.fim);
         chk({t, " quadro"},    int'(ifA.quadro),    v.q);
      end
   endtask

   initial begin
      int  hsCnt, areaCntA, vsCnt, areaCntB, peLowB, badInt, badVs, badArea;
      int  lastFim, fimSeen, fimCnt, budget;
      bit  aStarted, bStarted, found;

      // Expected values after n clks since release (A: pixel p=(n-1)/2,
      // pixelEn on even n; B: pixel p=n-1, 14 px/line, 7 lines/frame)
      tbl.push_back(mk(1,    1, 0,   0, 1, 1, 1, 1, 0, 0));
      tbl.push_back(mk(1,    0, 0,   0, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(2,    0, 0,   0, 1, 1, 1, 1, 0, 0));
      tbl.push_back(mk(3,    0, 1,   0, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(9,    1, 8,   0, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(11,   1, 10,  0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(13,   1, 12,  0, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(14,   1, 13,  0, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(15,   1, 0,   1, 1, 1, 1, 1, 0, 0));
      tbl.push_back(mk(57,   1, 0,   4, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(71,   1, 0,   5, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(84,   1, 13,  5, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(85,   1, 0,   6, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(98,   1, 13,  6, 1, 1, 1, 0, 1, 0));
      tbl.push_back(mk(99,   1, 0,   0, 1, 1, 1, 1, 0, 1));
      tbl.push_back(mk(1280, 0, 639, 0, 1, 1, 1, 1, 0, 0));
      tbl.push_back(mk(1281, 0, 640, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1312, 0, 655, 0, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1313, 0, 656, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1504, 0, 751, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1505, 0, 752, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1600, 0, 799, 0, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1601, 0, 0,   1, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(3201, 0, 0,   2, 0, 1, 1, 1, 0, 0));

      // Reset held 5 clks
      rstA = 1'b1;
      rstB = 1'b1;
      repeat (5) tick();
      chk("rst A coluna",    int'(ifA.coluna),    0);
      chk("rst A linha",     int'(ifA.linha),     0);
      chk("rst A pixelEn",   int'(ifA.pixelEn),   0);
      chk("rst A hsync",     int'(ifA.hsync),     1);
      chk("rst A vsync",     int'(ifA.vsync),     1);
      chk("rst A areaAtiva", int'(ifA.areaAtiva), 1);
      chk("rst A quadro",    int'(ifA.quadro),    0);
      chk("rst A fimQuadro", int'(ifA.fimQuadro), 0);
      chk("rst B pixelEn",   int'(ifB.pixelEn),   0);
      chk("rst B hsync",     int'(ifB.hsync),     1);

      rstA = 1'b0;
      rstB = 1'b0;
      cyc  = 0;

      foreach (tbl[i]) begin
         while (cyc < tbl[i].n) tick();
         cmpVec(tbl[i]);
      end

      // Free run until B has completed 256 frames (cyc 256*98)
      hsCnt = 0; areaCntA = 0; vsCnt = 0; areaCntB = 0; peLowB = 0;
      badInt = 0; badVs = 0; badArea = 0; lastFim = 0; fimSeen = 0;
      aStarted = 1'b0; bStarted = 1'b0;
      while (cyc < 25088) begin
         tick();
         if (ifA.pixelEn) begin
            if (ifA.coluna == 10'd0) begin
               hsCnt = 0; areaCntA = 0; aStarted = 1'b1;
            end
            if (!ifA.hsync) hsCnt++;
            if (ifA.areaAtiva) areaCntA++;
            if (aStarted && ifA.coluna == 10'd799) begin
               chk("A hsync pixels per line", hsCnt, 96);
               chk("A active pixels per line", areaCntA, 640);
            end
         end
         if (!ifB.pixelEn) peLowB++;
         if (ifB.pixelEn && !ifB.vsync) vsCnt++;
         if (ifB.pixelEn && ifB.areaAtiva) areaCntB++;
         if (ifB.fimQuadro) begin
            fimSeen++;
            if (bStarted) begin
               if (int'(cyc) - lastFim != 98) badInt++;
               if (vsCnt != 14) badVs++;
               if (areaCntB != 32) badArea++;
            end
            bStarted = 1'b1;
            lastFim  = int'(cyc);
            vsCnt    = 0;
            areaCntB = 0;
         end
      end
      chk("B fim at frame 256",       int'(ifB.fimQuadro), 1);
      chk("B quadro before wrap",     int'(ifB.quadro),    255);
      chk("B fimQuadro period errs",  badInt,  0);
      chk("B vsync pixels/frame errs", badVs,  0);
      chk("B active pixels/frame errs", badArea, 0);
      chk("B pixelEn low clks",       peLowB,  0);
      chk("B fim pulses in run",      fimSeen, 224);
      tick();
      chk("B quadro wrapped",         int'(ifB.quadro),    0);
      chk("B coluna after wrap",      int'(ifB.coluna),    0);
      chk("B linha after wrap",       int'(ifB.linha),     0);
      chk("B fim after wrap",         int'(ifB.fimQuadro), 0);

      // Mid-line reset of A while hsync is active
      found = 1'b0;
      budget = 0;
      while (!found && budget < 2000) begin
         tick();
         budget++;
         if (ifA.coluna == 10'd700) found = 1'b1;
      end
      chk("A reach coluna 700", int'(found), 1);
      chk("A hsync at 700",     int'(ifA.hsync), 0);
      rstA = 1'b1;
      tick();
      chk("A midrst coluna",    int'(ifA.coluna),    0);
      chk("A midrst linha",     int'(ifA.linha),     0);
      chk("A midrst hsync",     int'(ifA.hsync),     1);
      chk("A midrst pixelEn",   int'(ifA.pixelEn),   0);
      chk("A midrst areaAtiva", int'(ifA.areaAtiva), 1);
      chk("A midrst fimQuadro", int'(ifA.fimQuadro), 0);
      rstA = 1'b0;
      tick();
      chk("A pixelEn 1 clk after release", int'(ifA.pixelEn), 0);
      tick();
      chk("A pixelEn 2 clk after release", int'(ifA.pixelEn), 1);

      // Mid-frame reset of B inside both sync pulses
      found = 1'b0;
      budget = 0;
      while (!found && budget < 200) begin
         tick();
         budget++;
         if (ifB.coluna == 10'd10 && ifB.linha == 10'd5) found = 1'b1;
      end
      chk("B reach (10,5)",  int'(found), 1);
      chk("B hsync at 10",   int'(ifB.hsync), 0);
      chk("B vsync at 5",    int'(ifB.vsync), 0);
      rstB = 1'b1;
      tick();
      chk("B midrst coluna", int'(ifB.coluna),    0);
      chk("B midrst linha",  int'(ifB.linha),     0);
      chk("B midrst hsync",  int'(ifB.hsync),     1);
      chk("B midrst vsync",  int'(ifB.vsync),     1);
      chk("B midrst quadro", int'(ifB.quadro),    0);
      chk("B midrst fim",    int'(ifB.fimQuadro), 0);
      rstB = 1'b0;
      fimCnt = 0;
      for (int k = 1; k <= 98; k++) begin
         tick();
         if (k == 1) chk("B pixelEn 1 clk after release", int'(ifB.pixelEn), 1);
         if (k < 98 && ifB.fimQuadro) fimCnt++;
      end
      chk("B early fim pulses", fimCnt, 0);
      chk("B fim at clk 98",    int'(ifB.fimQuadro), 1);
      chk("B quadro at clk 98", int'(ifB.quadro),    0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sincronizador.md
Name: vga_sincronizador

Overview:
VGA 640x480@60 Hz timing generator. It sits directly upstream of every per-ship drawing stage and of the board/grid painter. It derives the pixel-rate enable from the system clock and produces the linha/coluna scan coordinates, areaAtiva, hsync and vsync, plus frame-level strobes. All drawing stages sample linha, coluna and areaAtiva from this block on the same clk.

Parameters:
DIV_PIXEL, 2, system clocks per pixel (2 gives 25 MHz from 50 MHz); legal range 1..4.
H_VIS, 640, visible columns.
H_FP, 16, horizontal front porch (pixels).
H_SYNC, 96, horizontal sync width (pixels).
H_BP, 48, horizontal back porch (pixels).
V_VIS, 480, visible lines.
V_FP, 10, vertical front porch (lines).
V_SYNC, 2, vertical sync width (lines).
V_BP, 33, vertical back porch (lines).
SYNC_POL, 0, sync active level (0 = active-low).

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
pixelEn  out  1  one-clk pulse per pixel period
coluna  out  10  current column, 0..H_TOTAL-1
linha  out  10  current line, 0..V_TOTAL-1
areaAtiva  out  1  high when coluna<H_VIS and linha<V_VIS
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
fimQuadro  out  1  one-clk pulse on the last pixel of a frame
quadro  out  8  frame counter, wraps 255->0

Behaviour:
- Totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525). Counters are 10-bit.
- Divider: div counts 0..DIV_PIXEL-1 each clk. pixelEn=1 in the clk where div==DIV_PIXEL-1. With DIV_PIXEL=1, pixelEn is constantly 1 after reset.
- Scan counters: advance only on pixelEn.
  - coluna increments; at H_TOTAL-1 it wraps to 0 and linha increments.
  - linha at V_TOTAL-1, on that wrap, goes to 0 and quadro increments (mod 256).
- Registered outputs: coluna, linha, hsync, vsync, areaAtiva, fimQuadro are all registered. hsync/vsync/areaAtiva are computed from the next counter value, so in every clk they decode exactly the coluna/linha currently driven. Coordinate-to-flag latency is 0; any counter to output latency is 1 clk.
- hsync: active (=SYNC_POL) for H_VIS+H_FP <= coluna < H_VIS+H_FP+H_SYNC (656..751); inactive elsewhere.
- vsync: active for V_VIS+V_FP <= linha < V_VIS+V_FP+V_SYNC (490..491), for the whole line including porches.
- areaAtiva: (coluna<H_VIS)&&(linha<V_VIS). Blank region 640..799 / 480..524 gives 0.
- fimQuadro: 1 in the single clk where pixelEn=1, coluna=H_TOTAL-1 and linha=V_TOTAL-1; otherwise 0.
- Reset values, driven the clk after reset is sampled high and held while reset=1:
  - div=0, pixelEn=0, coluna=0, linha=0, quadro=0, fimQuadro=0.
  - hsync=vsync=~SYNC_POL (inactive).
  - areaAtiva=1, consistent with position (0,0).
- Reset mid-frame: counters abort immediately to (0,0) with no partial sync pulse stretched. The first pixelEn after release occurs DIV_PIXEL clks after reset deasserts.
- Frame period: exactly DIV_PIXEL*H_TOTAL*V_TOTAL clks (840000 at defaults). No drift; every line has exactly H_TOTAL pixelEn pulses.
- No other inputs; the block is free-running after reset.

Test Plan:
- Reset: hold reset 5 clks -> coluna=0, linha=0, hsync=vsync=1, areaAtiva=1, quadro=0, fimQuadro=0. First pixelEn 2 clks after release.
- Horizontal timing (defaults): count pixelEn from coluna=0 -> hsync low exactly for coluna 656..751 (96 pixels), areaAtiva falls at coluna 640, coluna 799->0 with linha +1.
- Vertical timing: run 525 lines -> vsync low exactly for linha 490..491 (1600 pixelEn), areaAtiva=0 for all linha>=480, linha 524->0.
- Frame strobe: from reset release, fimQuadro pulses once at clk 840000, again at 1680000; quadro goes 0->1->2. Force 256 frames (short totals) -> quadro wraps to 0.
- Mid-frame reset: assert reset at coluna=700, linha=300 during hsync -> next clk hsync=1, coluna=linha=0, no extra fimQuadro.
- DIV_PIXEL=1, small totals (H 8/2/2/2, V 4/1/1/1): pixelEn constant 1, hsync active for coluna 10..11, frame period 14*7=98 clks.
